// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: free-running pc+4 with branch, exception and eret redirects,
// stall-deferred redirects, and a sticky fault state on illegal fetch addresses.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h3000,
  parameter logic [31:0] PC_LOW    = 32'h3000,
  parameter logic [31:0] PC_HIGH   = 32'h4ffc,
  parameter logic [31:0] EXC_ENTRY = 32'h4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        adel,
  output logic        redirect_pending
);

  typedef enum logic [1:0] {RUN, PEND, FAULT} st_t;

  st_t         st;
  logic [31:0] pend_target;
  logic [31:0] pc_inc;

  // Wraps modulo 2^32; a wrapped pc is caught by the range check below.
  assign pc_inc = pc + 32'd4;

  assign adel             = (pc < PC_LOW) | (pc > PC_HIGH) | (pc[1:0] != 2'b00);
  assign pc_valid         = !adel && (st != FAULT);
  assign redirect_pending = (st == PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      st          <= RUN;
      pend_target <= '0;
    end else if (exc_req) begin
      pc          <= EXC_ENTRY;
      st          <= RUN;
      pend_target <= '0;
    end else if (eret_req) begin
      pc          <= epc;
      st          <= RUN;
      pend_target <= '0;
    end else begin
      case (st)
        RUN: begin
          if (stall) begin
            // A redirect that arrives while frozen is parked until the stall lifts.
            if (br_valid) begin
              pend_target <= br_target;
              st          <= PEND;
            end
          end else if (adel) begin
            st <= FAULT;
          end else begin
            pc <= br_valid ? br_target : pc_inc;
          end
        end
        PEND: begin
          if (stall) begin
            if (br_valid) pend_target <= br_target;
          end else begin
            pc <= br_valid ? br_target : pend_target;
            st <= RUN;
          end
        end
        FAULT: st <= FAULT;
        default: st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// expected outputs from a behavioural model pushed per cycle, popped by a monitor.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h3000;
  localparam logic [31:0] PC_LOW    = 32'h3000;
  localparam logic [31:0] PC_HIGH   = 32'h4ffc;
  localparam logic [31:0] EXC_ENTRY = 32'h4180;

  logic        clk = 1'b0;
  logic        reset, stall, br_valid, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc;
  logic        pc_valid, adel, redirect_pending;

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .PC_LOW   (PC_LOW),
    .PC_HIGH  (PC_HIGH),
    .EXC_ENTRY(EXC_ENTRY)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .adel            (adel),
    .redirect_pending(redirect_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        adel;
    logic        pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: fetch address, "a redirect is parked", "stuck on a fault".
  logic [31:0] m_pc;
  logic [31:0] m_parked;
  bit          m_has_parked;
  bit          m_stuck;

  function automatic bit illegal(input logic [31:0] a);
    return (a < PC_LOW) || (a > PC_HIGH) || (a % 4 != 0);
  endfunction

  // Next fetch address decided from the priority list, applied to the model.
  task automatic model(input bit rst, input bit stl, input bit br, input logic [31:0] tgt,
                       input bit exc, input bit ert, input logic [31:0] ep);
    if (rst) begin
      m_pc = RESET_PC; m_stuck = 0; m_has_parked = 0; m_parked = 0;
    end else if (exc) begin
      m_pc = EXC_ENTRY; m_stuck = 0; m_has_parked = 0;
    end else if (ert) begin
      m_pc = ep; m_stuck = 0; m_has_parked = 0;
    end else if (m_stuck) begin
      // stays put until exception or eret
    end else if (m_has_parked) begin
      if (stl) begin
        if (br) m_parked = tgt;
      end else begin
        m_pc = br ? tgt : m_parked;
        m_has_parked = 0;
      end
    end else if (stl) begin
      if (br) begin m_parked = tgt; m_has_parked = 1; end
    end else if (illegal(m_pc)) begin
      m_stuck = 1;
    end else begin
      m_pc = br ? tgt : m_pc + 32'd4;
    end
  endtask

  task automatic step(input bit rst, input bit stl, input bit br, input logic [31:0] tgt,
                      input bit exc, input bit ert, input logic [31:0] ep);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; br_valid = br; br_target = tgt;
    exc_req = exc; eret_req = ert; epc = ep;
    model(rst, stl, br, tgt, exc, ert, ep);
    e.pc    = m_pc;
    e.adel  = illegal(m_pc);
    e.valid = !e.adel && !m_stuck;
    e.pend  = m_has_parked;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 32'h0);
  endtask

  // Monitor: the DUT presents a new fetch slot after every edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pc !== e.pc) begin
        errors++; $display("FAIL pc got %h exp %h at %0t", pc, e.pc, $time);
      end
      checks++;
      if (adel !== e.adel) begin
        errors++; $display("FAIL adel got %b exp %b pc %h at %0t", adel, e.adel, pc, $time);
      end
      checks++;
      if (pc_valid !== e.valid) begin
        errors++; $display("FAIL pc_valid got %b exp %b pc %h at %0t", pc_valid, e.valid, pc, $time);
      end
      checks++;
      if (redirect_pending !== e.pend) begin
        errors++; $display("FAIL redirect_pending got %b exp %b at %0t", redirect_pending, e.pend, $time);
      end
    end
  end

  logic [31:0] rt;

  initial begin
    reset = 1; stall = 0; br_valid = 0; br_target = 0; exc_req = 0; eret_req = 0; epc = 0;
    m_pc = 0; m_parked = 0; m_has_parked = 0; m_stuck = 0;

    // reset, free run to 3010
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 0, 32'h0);
    idle(4);
    // stalled branch to 3100 held two cycles, then released
    step(0, 1, 1, 32'h3100, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    // latest parked target wins
    step(0, 1, 1, 32'h3200, 0, 0, 32'h0);
    step(0, 1, 1, 32'h3300, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    // exception while parked and stalled
    step(0, 1, 1, 32'h3400, 0, 0, 32'h0);
    step(0, 1, 0, 32'h0, 1, 0, 32'h0);
    idle(1);
    // out-of-range branch -> fault, stall and branches ignored, exit by exception
    step(0, 0, 1, 32'h5000, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 0, 32'h0);
    step(0, 1, 1, 32'h3000, 0, 0, 32'h0);
    step(0, 0, 1, 32'h3000, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 0, 32'h0);
    // top of range runs off the end; misaligned eret
    step(0, 0, 1, 32'h4ffc, 0, 0, 32'h0);
    idle(2);
    step(0, 0, 0, 32'h0, 0, 1, 32'h3002);
    idle(1);
    // all redirects together, then with reset on the same edge
    step(0, 0, 1, 32'h3800, 1, 1, 32'h3900);
    step(1, 1, 1, 32'h3800, 1, 1, 32'h3900);
    // reset discards a parked redirect
    step(0, 1, 1, 32'h3a00, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 0, 0, 32'h0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      rt = 32'h3000 + ($urandom_range(0, 32'h7ff) << 2);
      if ($urandom_range(0, 9) == 0) rt = $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, rt,
           $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
           ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h7ff) << 2));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++; $display("FAIL drain %0d entries left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
